// File: rtl/code_stream_loader.sv
// rtl/code_stream_loader.sv - streams code words into code storage, then starts execution
module code_stream_loader #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic              append,
    input  logic              halt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [LINE_W-1:0] code_storage_write_interface_write_line,
    output logic [DATA_W-1:0] code_storage_write_interface_write_data,
    output logic              code_storage_write_interface_is_write,
    output logic              code_storage_code_control_interface_reset,
    output logic              code_storage_code_control_interface_active,
    output logic [LINE_W-1:0] loaded_count,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RST,
        S_RUN,
        S_ERR
    } state_t;

    // Pointer carries one extra bit so a completely full store (DEPTH lines) is representable.
    localparam logic [LINE_W:0] DEPTH_L = (LINE_W+1)'(DEPTH);
    localparam logic [LINE_W:0] ONE_L   = (LINE_W+1)'(1);

    state_t              state_q, state_d;
    logic [LINE_W:0]     ptr_q, ptr_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_q, wr_d;
    logic [LINE_W-1:0]   wr_line_q, wr_line_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                ctl_rst_q, ctl_rst_d;
    logic                active_q, active_d;
    logic                overflow_q, overflow_d;
    logic                accept;

    // Next-state and next-output computation; outputs are derived from the next state so they come straight off flops.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        overflow_d = overflow_q;
        wr_d       = 1'b0;
        wr_line_d  = wr_line_q;
        wr_data_d  = wr_data_q;
        accept     = in_valid & in_ready_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    overflow_d = 1'b0;
                    if (!append) begin
                        ptr_d = '0;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_d      = 1'b1;
                    wr_line_d = ptr_q[LINE_W-1:0];
                    wr_data_d = in_data;
                    ptr_d     = ptr_q + ONE_L;
                end
                // halt beats in_last; a word offered to a full store is a capacity error
                if (halt) begin
                    state_d = S_IDLE;
                end else if (accept && in_last) begin
                    state_d = S_FLUSH;
                end else if (in_valid && (ptr_q == DEPTH_L)) begin
                    state_d    = S_ERR;
                    overflow_d = 1'b1;
                end
            end
            S_FLUSH: state_d = S_RST;
            S_RST:   state_d = S_RUN;
            S_RUN: begin
                if (halt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD) && (ptr_d < DEPTH_L);
        ctl_rst_d  = (state_d == S_RST);
        active_d   = (state_d == S_RUN);
    end

    // State and registered outputs; reset clears everything, including a pending write strobe.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            wr_line_q  <= '0;
            wr_data_q  <= '0;
            ctl_rst_q  <= 1'b0;
            active_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            in_ready_q <= in_ready_d;
            wr_q       <= wr_d;
            wr_line_q  <= wr_line_d;
            wr_data_q  <= wr_data_d;
            ctl_rst_q  <= ctl_rst_d;
            active_q   <= active_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready                                   = in_ready_q;
    assign code_storage_write_interface_write_line    = wr_line_q;
    assign code_storage_write_interface_write_data    = wr_data_q;
    assign code_storage_write_interface_is_write      = wr_q;
    assign code_storage_code_control_interface_reset  = ctl_rst_q;
    assign code_storage_code_control_interface_active = active_q;
    assign loaded_count                               = ptr_q[LINE_W-1:0];
    assign overflow                                   = overflow_q;

endmodule

// File: tb/tb_code_stream_loader.sv
// tb/tb_code_stream_loader.sv - self-checking bench for code_stream_loader
module tb_code_stream_loader;

    localparam int DATA_W = 12;
    localparam int LINE_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              append = 1'b0;
    logic              halt = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic [LINE_W-1:0] wr_line;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              ctl_rst;
    logic              active;
    logic [LINE_W-1:0] count;
    logic              ovf;

    int errors = 0;
    int checks = 0;

    code_stream_loader #(.DATA_W(DATA_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
        .clk_clk                                    (clk),
        .reset_reset                                (rst),
        .start                                      (start),
        .append                                     (append),
        .halt                                       (halt),
        .in_valid                                   (in_valid),
        .in_ready                                   (in_ready),
        .in_data                                    (in_data),
        .in_last                                    (in_last),
        .code_storage_write_interface_write_line    (wr_line),
        .code_storage_write_interface_write_data    (wr_data),
        .code_storage_write_interface_is_write      (wr_en),
        .code_storage_code_control_interface_reset  (ctl_rst),
        .code_storage_code_control_interface_active (active),
        .loaded_count                               (count),
        .overflow                                   (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; halt = 1'b1;
        tick; tick;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; halt = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_is_write got %0b want 0", wr_en); end
        checks++; if (wr_line !== 32'd0) begin errors++; $display("FAIL rst_line got %0h want 0", wr_line); end
        checks++; if (wr_data !== 12'd0) begin errors++; $display("FAIL rst_data got %0h want 0", wr_data); end
        checks++; if (ctl_rst !== 1'b0) begin errors++; $display("FAIL rst_ctl_reset got %0b want 0", ctl_rst); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b want 0", active); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b want 0", ovf); end
    endtask

    task automatic test_basic;
        logic [DATA_W-1:0] words [3];
        words[0] = 12'h001; words[1] = 12'h002; words[2] = 12'h003;
        start = 1'b1; append = 1'b0; tick; start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i]; in_last = (i == 2);
            tick;
            checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr%0d got %0b want 1", i, wr_en); end
            checks++; if (wr_line !== 32'(i)) begin errors++; $display("FAIL basic_line%0d got %0d want %0d", i, wr_line, i); end
            checks++; if (wr_data !== words[i]) begin errors++; $display("FAIL basic_data%0d got %0h want %0h", i, wr_data, words[i]); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_flush_ready got %0b want 0", in_ready); end
        tick;
        checks++; if (ctl_rst !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL basic_pulse got rst=%0b wr=%0b want rst=1 wr=0", ctl_rst, wr_en); end
        tick;
        checks++; if (ctl_rst !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL basic_run got rst=%0b act=%0b want 0 1", ctl_rst, active); end
        checks++; if (count !== 32'd3) begin errors++; $display("FAIL basic_count got %0d want 3", count); end
        start = 1'b1; tick; start = 1'b0;
        checks++; if (active !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL run_start_ignored got act=%0b rdy=%0b want 1 0", active, in_ready); end
    endtask

    task automatic test_append;
        halt = 1'b1; tick; halt = 1'b0;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL app_halt got %0b want 0", active); end
        start = 1'b1; append = 1'b1; tick; start = 1'b0; append = 1'b0;
        checks++; if (count !== 32'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL app_start got cnt=%0d rdy=%0b want 3 1", count, in_ready); end
        in_valid = 1'b1; in_data = 12'hABC; in_last = 1'b1; tick; in_valid = 1'b0; in_last = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_line !== 32'd3 || wr_data !== 12'hABC) begin errors++; $display("FAIL app_write got wr=%0b line=%0d data=%0h want 1 3 abc", wr_en, wr_line, wr_data); end
        checks++; if (count !== 32'd4) begin errors++; $display("FAIL app_count got %0d want 4", count); end
        tick; tick;
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL app_active got %0b want 1", active); end
        halt = 1'b1; tick; halt = 1'b0;
    endtask

    task automatic test_overflow;
        start = 1'b1; append = 1'b0; tick; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 12'(16 + i); tick;
            checks++; if (wr_en !== 1'b1 || wr_line !== 32'(i)) begin errors++; $display("FAIL ovf_wr%0d got wr=%0b line=%0d want 1 %0d", i, wr_en, wr_line, i); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_full_ready got %0b want 0", in_ready); end
        in_data = 12'h055; tick;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ovf_fifth_write got %0b want 0", wr_en); end
        checks++; if (ovf !== 1'b1 || in_ready !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL ovf_err got ovf=%0b rdy=%0b act=%0b want 1 0 0", ovf, in_ready, active); end
        in_valid = 1'b0; halt = 1'b1; tick; halt = 1'b0;
        checks++; if (ovf !== 1'b1 || count !== 32'd4) begin errors++; $display("FAIL ovf_sticky got ovf=%0b cnt=%0d want 1 4", ovf, count); end
        start = 1'b1; tick; start = 1'b0;
        checks++; if (ovf !== 1'b0 || in_ready !== 1'b1 || count !== 32'd0) begin errors++; $display("FAIL ovf_clear got ovf=%0b rdy=%0b cnt=%0d want 0 1 0", ovf, in_ready, count); end
        halt = 1'b1; tick; halt = 1'b0;
    endtask

    task automatic test_gap;
        logic exp_wr [5];
        logic exp_rst [5];
        exp_wr[0] = 1; exp_wr[1] = 0; exp_wr[2] = 1; exp_wr[3] = 0; exp_wr[4] = 0;
        exp_rst[0] = 0; exp_rst[1] = 0; exp_rst[2] = 0; exp_rst[3] = 1; exp_rst[4] = 0;
        start = 1'b1; append = 1'b0; tick; start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 0 || c == 2); in_last = (c == 2); in_data = 12'(c + 7);
            tick;
            checks++; if (wr_en !== exp_wr[c] || ctl_rst !== exp_rst[c]) begin errors++; $display("FAIL gap_c%0d got wr=%0b rst=%0b want %0b %0b", c, wr_en, ctl_rst, exp_wr[c], exp_rst[c]); end
            if (c == 2) begin
                checks++; if (wr_line !== 32'd1) begin errors++; $display("FAIL gap_line got %0d want 1", wr_line); end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (active !== 1'b1 || count !== 32'd2) begin errors++; $display("FAIL gap_run got act=%0b cnt=%0d want 1 2", active, count); end
        halt = 1'b1; tick; halt = 1'b0;
    endtask

    task automatic test_reset_mid;
        start = 1'b1; append = 1'b0; tick; start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 12'(32 + i); tick;
        end
        checks++; if (wr_en !== 1'b1 || wr_line !== 32'd2) begin errors++; $display("FAIL rmid_pre got wr=%0b line=%0d want 1 2", wr_en, wr_line); end
        rst = 1'b1; in_data = 12'h0EE; tick; rst = 1'b0; in_valid = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rmid_write got %0b want 0", wr_en); end
        checks++; if (count !== 32'd0 || active !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_state got cnt=%0d act=%0b rdy=%0b want 0 0 0", count, active, in_ready); end
    endtask

    // Session-level model: the n-th accepted word of a session lands on line base+n, accepts only while lines remain.
    task automatic test_random;
        int ptr;
        ptr = 0;
        for (int s = 0; s < 40; s++) begin
            int  base;
            logic ap;
            logic done;
            ap = 1'($urandom_range(0, 1));
            base = ap ? ptr : 0;
            start = 1'b1; append = ap; tick; start = 1'b0; append = 1'b0;
            ptr = base;
            checks++; if (count !== 32'(base) || ovf !== 1'b0 || in_ready !== (base < DEPTH)) begin errors++; $display("FAIL rnd_start s%0d got cnt=%0d ovf=%0b rdy=%0b want %0d 0 %0b", s, count, ovf, in_ready, base, base < DEPTH); end
            done = 1'b0;
            for (int c = 0; c < 12 && !done; c++) begin
                logic v, l, h, acc;
                logic [DATA_W-1:0] d;
                v = ($urandom_range(0, 9) < 7);
                l = ($urandom_range(0, 9) < 2);
                h = ($urandom_range(0, 24) == 0);
                d = 12'($urandom);
                acc = v && (ptr < DEPTH);
                in_valid = v; in_last = l; halt = h; in_data = d;
                tick;
                in_valid = 1'b0; in_last = 1'b0; halt = 1'b0;
                checks++; if (wr_en !== acc) begin errors++; $display("FAIL rnd_wr s%0d c%0d got %0b want %0b", s, c, wr_en, acc); end
                if (acc) begin
                    checks++; if (wr_line !== 32'(ptr) || wr_data !== d) begin errors++; $display("FAIL rnd_wdata s%0d c%0d got line=%0d data=%0h want %0d %0h", s, c, wr_line, wr_data, ptr, d); end
                    ptr++;
                end
                checks++; if (count !== 32'(ptr)) begin errors++; $display("FAIL rnd_count s%0d c%0d got %0d want %0d", s, c, count, ptr); end
                if (h) begin
                    checks++; if (in_ready !== 1'b0 || ctl_rst !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL rnd_halt s%0d got rdy=%0b rst=%0b act=%0b want 0 0 0", s, in_ready, ctl_rst, active); end
                    done = 1'b1;
                end else if (acc && l) begin
                    tick;
                    checks++; if (ctl_rst !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL rnd_pulse s%0d got rst=%0b wr=%0b want 1 0", s, ctl_rst, wr_en); end
                    tick;
                    checks++; if (active !== 1'b1 || ctl_rst !== 1'b0) begin errors++; $display("FAIL rnd_run s%0d got act=%0b rst=%0b want 1 0", s, active, ctl_rst); end
                    halt = 1'b1; tick; halt = 1'b0;
                    done = 1'b1;
                end else if (v && !acc) begin
                    checks++; if (ovf !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rnd_ovf s%0d got ovf=%0b rdy=%0b want 1 0", s, ovf, in_ready); end
                    done = 1'b1;
                end else begin
                    checks++; if (in_ready !== (ptr < DEPTH)) begin errors++; $display("FAIL rnd_ready s%0d c%0d got %0b want %0b", s, c, in_ready, ptr < DEPTH); end
                end
            end
            if (!done) begin
                halt = 1'b1; tick; halt = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_append;
        test_overflow;
        test_gap;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
